// File: rtl/sa_pkg.sv
// Shared types, default sizes and arithmetic helpers for the
// weight-stationary systolic matrix-vector engine.
package sa_pkg;

  localparam int SA_ROWS   = 16;
  localparam int SA_COLS   = 16;
  localparam int SA_DATA_W = 8;
  localparam int SA_ACC_W  = 16;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    READY = 2'd1,
    DRAIN = 2'd2
  } sa_state_e;

  function automatic int sa_latency(
    input int rows,
    input int cols
  );
    return rows + cols - 1;
  endfunction

  // Clamp a wide signed value into the w-bit signed range.
  function automatic logic signed [63:0] sa_clamp(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] sa_sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 w
  );
    return sa_clamp(a + b, w);
  endfunction

endpackage

// File: rtl/systolic_array_ws_pe.sv
// ws_pe: one weight-stationary processing element.
// Ports: clk, reset_n (async, active-low); w_shift loads w_in into
//   the weight register; a_in -> a_out pass-through register;
//   psum_out <= psum_in + a_in * weight.
// SA_SATURATE_EN: saturating product and add instead of wrap.
module ws_pe
  import sa_pkg::*;
#(
  parameter int DATA_W = SA_DATA_W,
  parameter int ACC_W  = SA_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     w_shift,
  input  logic signed [DATA_W-1:0] w_in,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [ACC_W-1:0]  psum_in,
  output logic signed [DATA_W-1:0] w_out,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [ACC_W-1:0]  psum_out
);

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] sum;

  assign prod = PW'(a_in) * PW'(w_out);

`ifdef SA_SATURATE_EN
  assign sum = ACC_W'(sa_sat_add(64'(psum_in),
                                 sa_clamp(64'(prod), ACC_W),
                                 ACC_W));
`else
  assign sum = ACC_W'(64'(psum_in) + 64'(prod));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_out    <= '0;
      a_out    <= '0;
      psum_out <= '0;
    end else begin
      if (w_shift) w_out <= w_in;
      a_out    <= a_in;
      psum_out <= sum;
    end
  end

endmodule

// File: rtl/systolic_array_ws.sv
// systolic_array_ws: ROWSxCOLS weight-stationary matrix-vector engine
// with input skew, output deskew, serial weight load and LOAD/READY/DRAIN
// control.
// Ports: clk, reset_n (async, active-low); w_valid/w_ready/w_data weight
//   rows (bottom row first); in_valid/in_ready/in_data activations;
//   out_valid/out_data column sums, ROWS+COLS-1 cycles after accept; busy.
// SA_SATURATE_EN: saturating arithmetic in every PE.
module systolic_array_ws
  import sa_pkg::*;
#(
  parameter int ROWS   = SA_ROWS,
  parameter int COLS   = SA_COLS,
  parameter int DATA_W = SA_DATA_W,
  parameter int ACC_W  = SA_ACC_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [COLS*DATA_W-1:0] w_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] in_data,
  output logic                   out_valid,
  output logic [COLS*ACC_W-1:0]  out_data,
  output logic                   busy
);

  localparam int L  = sa_latency(ROWS, COLS);
  localparam int CW = $clog2(L + 1);
  localparam int RW = $clog2(ROWS + 1);

  sa_state_e     state;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] inflight;
  logic [L-1:0]  vld;
  logic          accept;
  logic          w_shift;
  logic          emit;

  assign w_ready  = (state == LOAD);
  assign in_ready = (state == READY);
  assign busy     = (state != READY) || (inflight != '0);
  assign accept   = in_valid & in_ready;
  assign w_shift  = w_valid & w_ready;
  assign emit     = vld[L-1];

  logic signed [DATA_W-1:0] w_q  [ROWS][COLS];
  logic signed [DATA_W-1:0] a_q  [ROWS][COLS];
  logic signed [ACC_W-1:0]  ps_q [ROWS][COLS];

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] a_col0;

    assign x_in = accept ? in_data[i*DATA_W +: DATA_W] : '0;

    // Row i waits i cycles so its element meets the psum wavefront.
    if (i == 0) begin : g_direct
      assign a_col0 = x_in;
    end else begin : g_skew
      logic signed [DATA_W-1:0] sk [i];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < i; k++) sk[k] <= '0;
        end else begin
          sk[0] <= x_in;
          for (int k = 1; k < i; k++) sk[k] <= sk[k-1];
        end
      end
      assign a_col0 = sk[i-1];
    end

    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic signed [DATA_W-1:0] w_in;
      logic signed [DATA_W-1:0] a_in;
      logic signed [ACC_W-1:0]  p_in;

      if (i == 0) begin : g_top
        assign w_in = w_data[j*DATA_W +: DATA_W];
        assign p_in = '0;
      end else begin : g_mid
        assign w_in = w_q[i-1][j];
        assign p_in = ps_q[i-1][j];
      end

      if (j == 0) begin : g_left
        assign a_in = a_col0;
      end else begin : g_right
        assign a_in = a_q[i][j-1];
      end

      ws_pe #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk     (clk),
        .reset_n (reset_n),
        .w_shift (w_shift),
        .w_in    (w_in),
        .a_in    (a_in),
        .psum_in (p_in),
        .w_out   (w_q[i][j]),
        .a_out   (a_q[i][j]),
        .psum_out(ps_q[i][j])
      );

      if (i == ROWS - 1) begin : g_wsink
        logic unused_w;
        assign unused_w = ^w_q[i][j];
      end
      if (j == COLS - 1) begin : g_asink
        logic unused_a;
        assign unused_a = ^a_q[i][j];
      end
    end
  end

  // Column j finishes j cycles after column 0; pad to align all columns.
  for (genvar j = 0; j < COLS; j++) begin : g_out
    localparam int D = COLS - 1 - j;
    logic signed [ACC_W-1:0] tail;
    logic signed [ACC_W-1:0] out_q;

    if (D == 0) begin : g_nodly
      assign tail = ps_q[ROWS-1][j];
    end else begin : g_dly
      logic signed [ACC_W-1:0] ds [D];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < D; k++) ds[k] <= '0;
        end else begin
          ds[0] <= ps_q[ROWS-1][j];
          for (int k = 1; k < D; k++) ds[k] <= ds[k-1];
        end
      end
      assign tail = ds[D-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) out_q <= '0;
      else if (emit) out_q <= tail;
    end

    assign out_data[j*ACC_W +: ACC_W] = out_q;
  end

  // Count retires on the edge that raises out_valid, keeping it in 0..L.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld       <= '0;
      out_valid <= 1'b0;
      inflight  <= '0;
    end else begin
      vld       <= L'({vld, accept});
      out_valid <= emit;
      unique case ({accept, emit})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= LOAD;
      row_cnt <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (w_valid) begin
            if (row_cnt == RW'(ROWS - 1)) begin
              state   <= READY;
              row_cnt <= '0;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        READY: begin
          if (w_valid) state <= DRAIN;
        end
        DRAIN: begin
          if (inflight == '0) begin
            state   <= LOAD;
            row_cnt <= '0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_array_ws.sv
// Scoreboard bench: a 4x4 and a 3x5 instance driven with directed and
// random traffic, checked against a matrix-vector reference model.
module tb_systolic_array_ws;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int RA = 4;
  localparam int CA = 4;
  localparam int LA = RA + CA - 1;
  localparam int RB = 3;
  localparam int CB = 5;
  localparam int LB = RB + CB - 1;

  typedef struct {
    logic [127:0] d;
    int           t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic             a_rst_n, a_w_valid, a_w_ready, a_in_valid;
  logic             a_in_ready, a_out_valid, a_busy;
  logic [CA*DW-1:0] a_w_data;
  logic [RA*DW-1:0] a_in_data;
  logic [CA*AW-1:0] a_out_data;

  logic             b_rst_n, b_w_valid, b_w_ready, b_in_valid;
  logic             b_in_ready, b_out_valid, b_busy;
  logic [CB*DW-1:0] b_w_data;
  logic [RB*DW-1:0] b_in_data;
  logic [CB*AW-1:0] b_out_data;

  systolic_array_ws #(
    .ROWS(RA), .COLS(CA), .DATA_W(DW), .ACC_W(AW)
  ) u_dut_a (
    .clk      (clk),
    .reset_n  (a_rst_n),
    .w_valid  (a_w_valid),
    .w_ready  (a_w_ready),
    .w_data   (a_w_data),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .in_data  (a_in_data),
    .out_valid(a_out_valid),
    .out_data (a_out_data),
    .busy     (a_busy)
  );

  systolic_array_ws #(
    .ROWS(RB), .COLS(CB), .DATA_W(DW), .ACC_W(AW)
  ) u_dut_b (
    .clk      (clk),
    .reset_n  (b_rst_n),
    .w_valid  (b_w_valid),
    .w_ready  (b_w_ready),
    .w_data   (b_w_data),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .in_data  (b_in_data),
    .out_valid(b_out_valid),
    .out_data (b_out_data),
    .busy     (b_busy)
  );

  int   wa [8][8];
  int   wb [8][8];
  exp_t qa [$];
  exp_t qb [$];
  int   a_last_acc = 0;

  logic [CA*DW-1:0] a_beats [RA];
  logic [CB*DW-1:0] b_beats [RB];

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // y[j] = sum_i x[i]*W[i][j], accumulated top row first.
  function automatic logic [127:0] ref_mv(input int x[8], input int w[8][8],
                                          input int rows, input int cols);
    logic [127:0] r;
    int acc;
    r = '0;
    for (int j = 0; j < cols; j++) begin
      acc = 0;
      for (int i = 0; i < rows; i++) begin
`ifdef SA_SATURATE_EN
        acc = sat(acc + sat(x[i] * w[i][j]));
`else
        acc = acc + x[i] * w[i][j];
`endif
      end
      r[j*AW +: AW] = acc[AW-1:0];
    end
    return r;
  endfunction

  function automatic logic [RA*DW-1:0] va(input int a0, input int a1,
                                          input int a2, input int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Reference bookkeeping: a new weight row enters row 0, older rows move down.
  always @(posedge clk) begin
    if (a_rst_n) begin
      if (a_in_valid && a_in_ready) begin
        int   xs [8];
        exp_t e;
        for (int i = 0; i < 8; i++) xs[i] = 0;
        for (int i = 0; i < RA; i++)
          xs[i] = int'($signed(a_in_data[i*DW +: DW]));
        e.d = ref_mv(xs, wa, RA, CA);
        e.t = cyc + 1;
        qa.push_back(e);
        a_last_acc = cyc + 1;
      end
      if (a_w_valid && a_w_ready) begin
        for (int i = RA - 1; i > 0; i--)
          for (int j = 0; j < CA; j++) wa[i][j] = wa[i-1][j];
        for (int j = 0; j < CA; j++)
          wa[0][j] = int'($signed(a_w_data[j*DW +: DW]));
      end
    end
  end

  always @(posedge clk) begin
    if (b_rst_n) begin
      if (b_in_valid && b_in_ready) begin
        int   xs [8];
        exp_t e;
        for (int i = 0; i < 8; i++) xs[i] = 0;
        for (int i = 0; i < RB; i++)
          xs[i] = int'($signed(b_in_data[i*DW +: DW]));
        e.d = ref_mv(xs, wb, RB, CB);
        e.t = cyc + 1;
        qb.push_back(e);
      end
      if (b_w_valid && b_w_ready) begin
        for (int i = RB - 1; i > 0; i--)
          for (int j = 0; j < CB; j++) wb[i][j] = wb[i-1][j];
        for (int j = 0; j < CB; j++)
          wb[0][j] = int'($signed(b_w_data[j*DW +: DW]));
      end
    end
  end

  always @(negedge clk) begin
    if (a_rst_n && a_out_valid) begin
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected_out: got out_valid=1 want 0");
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_out_data", 128'(a_out_data), e.d);
        check("a_latency", 128'(cyc - e.t), 128'(LA));
      end
    end
  end

  always @(negedge clk) begin
    if (b_rst_n && b_out_valid) begin
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected_out: got out_valid=1 want 0");
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_out_data", 128'(b_out_data), e.d);
        check("b_latency", 128'(cyc - e.t), 128'(LB));
      end
    end
  end

  task automatic a_load();
    for (int k = 0; k < RA; k++) begin
      int g;
      g = 0;
      a_w_valid = 1'b1;
      a_w_data  = a_beats[k];
      while (!a_w_ready && g < 200) begin
        @(posedge clk); #1; g++;
      end
      if (g >= 200) begin
        total++; bad++;
        $display("FAIL a_load_wait: got w_ready=0 want 1");
      end
      @(posedge clk); #1;
    end
    a_w_valid = 1'b0;
    check("a_in_ready_after_load", 128'(a_in_ready), 128'(1));
    check("a_busy_ready_idle", 128'(a_busy), 128'(0));
  endtask

  task automatic a_send(input logic [RA*DW-1:0] x);
    int g;
    g = 0;
    a_in_valid = 1'b1;
    a_in_data  = x;
    while (!a_in_ready && g < 200) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 200) begin
      total++; bad++;
      $display("FAIL a_send_wait: got in_ready=0 want 1");
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic a_wait();
    int g;
    g = 0;
    while (qa.size() != 0 && g < 300) begin
      @(negedge clk); g++;
    end
    check("a_drained", 128'(qa.size()), 128'(0));
    @(posedge clk); #1;
  endtask

  task automatic b_load();
    for (int k = 0; k < RB; k++) begin
      int g;
      g = 0;
      b_w_valid = 1'b1;
      b_w_data  = b_beats[k];
      while (!b_w_ready && g < 200) begin
        @(posedge clk); #1; g++;
      end
      if (g >= 200) begin
        total++; bad++;
        $display("FAIL b_load_wait: got w_ready=0 want 1");
      end
      @(posedge clk); #1;
    end
    b_w_valid = 1'b0;
    check("b_in_ready_after_load", 128'(b_in_ready), 128'(1));
  endtask

  task automatic b_send(input logic [RB*DW-1:0] x);
    int g;
    g = 0;
    b_in_valid = 1'b1;
    b_in_data  = x;
    while (!b_in_ready && g < 200) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 200) begin
      total++; bad++;
      $display("FAIL b_send_wait: got in_ready=0 want 1");
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic a_check_idle(input string nm);
    check({nm, "_w_ready"},   128'(a_w_ready),   128'(1));
    check({nm, "_in_ready"},  128'(a_in_ready),  128'(0));
    check({nm, "_out_valid"}, 128'(a_out_valid), 128'(0));
    check({nm, "_out_data"},  128'(a_out_data),  128'(0));
    check({nm, "_busy"},      128'(a_busy),      128'(1));
  endtask

  task automatic run_a();
    int acc_edge;
    int g;
    a_rst_n = 1'b0; a_w_valid = 1'b0; a_in_valid = 1'b0;
    a_w_data = '0; a_in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_check_idle("a_rst");
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    @(negedge clk);
    a_check_idle("a_post_rst");
    @(posedge clk); #1;

    // identity: beat k lands in row RA-1-k
    for (int k = 0; k < RA; k++) begin
      a_beats[k] = '0;
      a_beats[k][(RA-1-k)*DW +: DW] = 8'd1;
    end
    a_load();
    a_send(va(1, 2, 3, 4));
    a_wait();

    // all ones, back-to-back
    for (int k = 0; k < RA; k++) a_beats[k] = {RA{8'd1}};
    a_load();
    a_send(va(1, 1, 1, 1));
    a_send(va(2, 2, 2, 2));
    a_send(va(-3, 0, 0, 0));
    a_wait();

    // reload requested on the same edge a vector is accepted
    for (int k = 0; k < RA; k++) a_beats[k] = (CA*DW)'($urandom());
    a_in_valid = 1'b1;
    a_in_data  = (RA*DW)'($urandom());
    a_w_valid  = 1'b1;
    a_w_data   = a_beats[0];
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    acc_edge = a_last_acc;
    g = 0;
    while (!a_w_ready && g < 200) begin
      @(negedge clk); g++;
    end
    check("a_wready_after_drain", 128'(cyc), 128'(acc_edge + LA + 1));
    check("a_drain_out_seen", 128'(qa.size()), 128'(0));
    a_load();
    for (int n = 0; n < 4; n++) a_send((RA*DW)'($urandom()));
    a_wait();

    // overflow
    for (int k = 0; k < RA; k++) a_beats[k] = {RA{8'd127}};
    a_load();
    a_send(va(127, 127, 127, 127));
    a_wait();

    // random weights, random gaps
    for (int k = 0; k < RA; k++) a_beats[k] = (CA*DW)'($urandom());
    a_load();
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
      a_send((RA*DW)'($urandom()));
    end
    a_wait();

    // reset with three vectors in flight
    for (int k = 0; k < RA; k++) a_beats[k] = (CA*DW)'($urandom());
    a_load();
    for (int n = 0; n < 3; n++) a_send((RA*DW)'($urandom()));
    a_rst_n = 1'b0;
    qa.delete();
    foreach (wa[i, j]) wa[i][j] = 0;
    repeat (2) @(posedge clk);
    #1;
    a_rst_n = 1'b1;
    repeat (LA + 4) @(posedge clk);
    @(negedge clk);
    a_check_idle("a_mid_rst");
    @(posedge clk); #1;
    for (int k = 0; k < RA; k++) a_beats[k] = '0;
    a_load();
    a_send((RA*DW)'($urandom()));
    a_wait();
  endtask

  task automatic run_b();
    b_rst_n = 1'b0; b_w_valid = 1'b0; b_in_valid = 1'b0;
    b_w_data = '0; b_in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("b_rst_w_ready",  128'(b_w_ready),  128'(1));
    check("b_rst_in_ready", 128'(b_in_ready), 128'(0));
    check("b_rst_out_data", 128'(b_out_data), 128'(0));
    @(posedge clk); #1;
    b_rst_n = 1'b1;
    repeat (3) begin
      for (int k = 0; k < RB; k++)
        b_beats[k] = (CB*DW)'({$urandom(), $urandom()});
      b_load();
      for (int n = 0; n < 15; n++) begin
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk); #1;
        end
        b_send((RB*DW)'($urandom()));
      end
    end
    begin
      int g;
      g = 0;
      while (qb.size() != 0 && g < 300) begin
        @(negedge clk); g++;
      end
    end
    check("b_drained", 128'(qb.size()), 128'(0));
  endtask

  initial begin
    foreach (wa[i, j]) wa[i][j] = 0;
    foreach (wb[i, j]) wb[i][j] = 0;
    fork
      run_a();
      run_b();
    join
    repeat (LA + 4) @(posedge clk);
    check("a_queue_empty", 128'(qa.size()), 128'(0));
    check("b_queue_empty", 128'(qb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
